// File: rtl/mismatch_monitor.sv
// mismatch_monitor: compares NCH channels of observed vs expected data per
// accepted beat, reports per-channel mismatches one cycle later, and keeps
// sticky error status plus saturating beat/error statistics.
module mismatch_monitor #(
  parameter int WIDTH       = 32,
  parameter int NCH         = 4,
  parameter int CNT_W       = 16,
  parameter int HALT_ON_ERR = 1,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clr,
  input  logic                 test_mode,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] a_data,
  input  logic [NCH*WIDTH-1:0] b_data,
  output logic                 res_valid,
  output logic [NCH-1:0]       mismatch_vec,
  output logic                 err_flag,
  output logic [CH_W-1:0]      first_err_ch,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [1:0]           state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] HALT   = 2'd2;

  logic            accept;
  logic            any_err;
  logic            found;
  logic [NCH-1:0]  cmp_vec;
  logic [CH_W-1:0] low_ch;

  // Ready depends on clr combinationally so clr always wins over acceptance.
  assign in_ready = (state == ACTIVE) && !clr;
  assign accept   = in_valid && in_ready;
  assign any_err  = |cmp_vec;

  // Per-channel compare; self-test forces channel 0 regardless of its enable.
  always_comb begin
    cmp_vec = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cmp_vec[i] = ch_en[i] && (a_data[i*WIDTH +: WIDTH] != b_data[i*WIDTH +: WIDTH]);
    end
    if (test_mode) cmp_vec[0] = 1'b1;
  end

  // Lowest mismatching channel index of the current beat.
  always_comb begin
    low_ch = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cmp_vec[i] && !found) begin
        low_ch = CH_W'(i);
        found  = 1'b1;
      end
    end
  end

  // Control FSM: clr returns to IDLE from anywhere; HALT is left only via clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= ACTIVE;
        ACTIVE:  if (accept && any_err && (HALT_ON_ERR != 0)) state <= HALT;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Result strobe and mismatch vector, held until the next accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid    <= 1'b0;
      mismatch_vec <= '0;
    end else if (clr) begin
      res_valid    <= 1'b0;
      mismatch_vec <= '0;
    end else begin
      res_valid <= accept;
      if (accept) mismatch_vec <= cmp_vec;
    end
  end

  // Sticky error, first failing channel, and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag     <= 1'b0;
      first_err_ch <= '0;
      beat_cnt     <= '0;
      err_cnt      <= '0;
    end else if (clr) begin
      err_flag     <= 1'b0;
      first_err_ch <= '0;
      beat_cnt     <= '0;
      err_cnt      <= '0;
    end else if (accept) begin
      if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
      if (any_err) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        if (!err_flag) begin
          err_flag     <= 1'b1;
          first_err_ch <= low_ch;
        end
      end
    end
  end

endmodule

// File: tb/tb_mismatch_monitor.sv
// Bench for mismatch_monitor: default instance checked against a behavioural
// model, plus a CNT_W=4 / HALT_ON_ERR=0 instance for saturation behaviour.
module tb_mismatch_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults (WIDTH=32, NCH=4, CNT_W=16, HALT_ON_ERR=1)
  logic         start0, clr0, tm0, v0, rdy0, rv0, ef0;
  logic [3:0]   en0, mm0;
  logic [127:0] a0, b0;
  logic [1:0]   fc0, st0;
  logic [15:0]  bc0, ec0;

  // Instance 1: CNT_W=4, HALT_ON_ERR=0
  logic         start1, clr1, tm1, v1, rdy1, rv1, ef1;
  logic [3:0]   en1, mm1;
  logic [127:0] a1, b1;
  logic [1:0]   fc1, st1;
  logic [3:0]   bc1, ec1;

  mismatch_monitor #(.WIDTH(32), .NCH(4), .CNT_W(16), .HALT_ON_ERR(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .clr(clr0), .test_mode(tm0),
    .ch_en(en0), .in_valid(v0), .in_ready(rdy0), .a_data(a0), .b_data(b0),
    .res_valid(rv0), .mismatch_vec(mm0), .err_flag(ef0), .first_err_ch(fc0),
    .beat_cnt(bc0), .err_cnt(ec0), .state(st0));

  mismatch_monitor #(.WIDTH(32), .NCH(4), .CNT_W(4), .HALT_ON_ERR(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .clr(clr1), .test_mode(tm1),
    .ch_en(en1), .in_valid(v1), .in_ready(rdy1), .a_data(a1), .b_data(b1),
    .res_valid(rv1), .mismatch_vec(mm1), .err_flag(ef1), .first_err_ch(fc1),
    .beat_cnt(bc1), .err_cnt(ec1), .state(st1));

  int total = 0;
  int bad   = 0;

  // Reference model of instance 0 (state: 0 idle, 1 active, 2 halted)
  int       ms, mbeat, merr, mfch;
  bit       mrv, mflag;
  bit [3:0] mmm;

  task automatic model_reset();
    ms = 0; mbeat = 0; merr = 0; mfch = 0; mrv = 0; mflag = 0; mmm = 0;
  endtask

  // Advance one clock on instance 0 and apply the rules to the model.
  task automatic step0();
    bit       acc;
    bit [3:0] m;
    @(posedge clk);
    if (clr0) begin
      model_reset();
    end else begin
      acc = v0 && (ms == 1);
      mrv = acc;
      if (acc) begin
        m = 0;
        for (int i = 0; i < 4; i++)
          if (en0[i] && (a0[i*32 +: 32] != b0[i*32 +: 32])) m[i] = 1;
        if (tm0) m[0] = 1;
        mmm = m;
        if (mbeat < 65535) mbeat++;
        if (m != 0) begin
          if (merr < 65535) merr++;
          if (!mflag) begin
            mflag = 1;
            for (int i = 3; i >= 0; i--) if (m[i]) mfch = i;
          end
          ms = 2;
        end
      end
      if (ms == 0 && start0) ms = 1;
    end
    #1;
  endtask

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] exp_vec();
    return {2'(ms), mrv, mmm, mflag, 2'(mfch), 16'(mbeat), 16'(merr)};
  endfunction

  task automatic clr_start0();
    clr0 = 1; start0 = 0; v0 = 0; tm0 = 0; step0();
    clr0 = 0; start0 = 1; step0();
    start0 = 0;
  endtask

  task automatic test_reset();
    {start0, clr0, tm0, v0, en0, a0, b0} = '0;
    {start1, clr1, tm1, v1, en1, a1, b1} = '0;
    model_reset();
    #3;
    total++;
    if ({rdy0, rv0, mm0, ef0, fc0, bc0, ec0, st0} !== '0) begin
      bad++; $display("FAIL reset0 got=%h want=0", {rdy0, rv0, mm0, ef0, fc0, bc0, ec0, st0});
    end
    total++;
    if ({rdy1, rv1, mm1, ef1, fc1, bc1, ec1, st1} !== '0) begin
      bad++; $display("FAIL reset1 got=%h want=0", {rdy1, rv1, mm1, ef1, fc1, bc1, ec1, st1});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_pass();
    int pulses = 0;
    clr_start0();
    total++;
    if (st0 !== 2'd1 || rdy0 !== 1'b1) begin
      bad++; $display("FAIL start state=%0d ready=%b want 1/1", st0, rdy0);
    end
    en0 = 4'hF;
    for (int k = 0; k < 3; k++) begin
      a0 = {$urandom, $urandom, $urandom, $urandom}; b0 = a0; v0 = 1;
      step0();
      if (rv0 === 1'b1) pulses++;
    end
    v0 = 0; step0();
    if (rv0 === 1'b1) pulses++;
    total++;
    if (pulses != 3) begin
      bad++; $display("FAIL pass_pulses got=%0d want=3", pulses);
    end
    total++;
    if ({mm0, bc0, ec0, ef0} !== {4'h0, 16'd3, 16'd0, 1'b0}) begin
      bad++; $display("FAIL pass_stats mm=%h beat=%0d err=%0d flag=%b want 0/3/0/0", mm0, bc0, ec0, ef0);
    end
  endtask

  task automatic test_halt();
    a0 = {$urandom, $urandom, $urandom, $urandom}; b0 = a0;
    b0[64 +: 32] = ~a0[64 +: 32]; b0[96 +: 32] = ~a0[96 +: 32];
    v0 = 1; step0();
    total++;
    if ({mm0, ef0, fc0, st0, rdy0, rv0} !== {4'b1100, 1'b1, 2'd2, 2'd2, 1'b0, 1'b1}) begin
      bad++; $display("FAIL halt mm=%b flag=%b fch=%0d st=%0d rdy=%b rv=%b want 1100/1/2/2/0/1",
                      mm0, ef0, fc0, st0, rdy0, rv0);
    end
    start0 = 1; step0(); start0 = 0; v0 = 0;
    total++;
    if ({st0, rv0, bc0, ec0} !== {2'd2, 1'b0, 16'd4, 16'd1}) begin
      bad++; $display("FAIL halt_hold st=%0d rv=%b beat=%0d err=%0d want 2/0/4/1", st0, rv0, bc0, ec0);
    end
  endtask

  task automatic test_ch_en();
    clr_start0();
    en0 = 4'b1011;
    a0 = {$urandom, $urandom, $urandom, $urandom}; b0 = a0;
    b0[64 +: 32] = ~a0[64 +: 32];
    v0 = 1; step0(); v0 = 0;
    total++;
    if ({rv0, mm0, ec0, ef0, bc0} !== {1'b1, 4'b0000, 16'd0, 1'b0, 16'd1}) begin
      bad++; $display("FAIL ch_en rv=%b mm=%b err=%0d flag=%b beat=%0d want 1/0000/0/0/1", rv0, mm0, ec0, ef0, bc0);
    end
  endtask

  task automatic test_selftest();
    clr_start0();
    en0 = 4'b0000; tm0 = 1;
    a0 = {$urandom, $urandom, $urandom, $urandom}; b0 = a0;
    v0 = 1; step0(); v0 = 0; tm0 = 0;
    total++;
    if ({mm0, ef0, fc0, ec0, st0} !== {4'b0001, 1'b1, 2'd0, 16'd1, 2'd2}) begin
      bad++; $display("FAIL selftest mm=%b flag=%b fch=%0d err=%0d st=%0d want 0001/1/0/1/2", mm0, ef0, fc0, ec0, st0);
    end
  endtask

  task automatic test_random();
    clr_start0();
    for (int n = 0; n < 400; n++) begin
      clr0   = ($urandom_range(0, 39) == 0);
      start0 = ($urandom_range(0, 5) == 0);
      tm0    = ($urandom_range(0, 24) == 0);
      v0     = $urandom_range(0, 3) != 0;
      en0    = 4'($urandom);
      a0     = {$urandom, $urandom, $urandom, $urandom}; b0 = a0;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) b0[i*32 +: 32] = a0[i*32 +: 32] ^ (32'd1 << $urandom_range(0, 31));
      #1;
      total++;
      if (rdy0 !== ((ms == 1) && !clr0)) begin
        bad++; $display("FAIL rand_ready n=%0d got=%b want=%b", n, rdy0, (ms == 1) && !clr0);
      end
      step0();
      total++;
      if ({st0, rv0, mm0, ef0, fc0, bc0, ec0} !== exp_vec()) begin
        bad++; $display("FAIL rand_out n=%0d got=%h want=%h", n, {st0, rv0, mm0, ef0, fc0, bc0, ec0}, exp_vec());
      end
    end
    {clr0, start0, tm0, v0} = '0;
  endtask

  task automatic test_saturate();
    clr1 = 1; step1(); clr1 = 0; start1 = 1; step1(); start1 = 0;
    en1 = 4'hF;
    a1 = {$urandom, $urandom, $urandom, $urandom}; b1 = a1;
    b1[0 +: 32] = ~a1[0 +: 32];
    v1 = 1;
    for (int k = 0; k < 20; k++) step1();
    total++;
    if ({ec1, bc1, st1, ef1, fc1} !== {4'd15, 4'd15, 2'd1, 1'b1, 2'd0}) begin
      bad++; $display("FAIL saturate err=%0d beat=%0d st=%0d flag=%b fch=%0d want 15/15/1/1/0", ec1, bc1, st1, ef1, fc1);
    end
    clr1 = 1; #1;
    total++;
    if (rdy1 !== 1'b0) begin
      bad++; $display("FAIL clr_ready got=%b want=0", rdy1);
    end
    step1(); clr1 = 0; v1 = 0;
    total++;
    if ({ec1, bc1, st1, ef1, rv1, mm1, fc1} !== '0) begin
      bad++; $display("FAIL clr_all got=%h want=0", {ec1, bc1, st1, ef1, rv1, mm1, fc1});
    end
  endtask

  task automatic test_async_reset();
    int late = 0;
    clr_start0();
    en0 = 4'hF;
    a0 = {$urandom, $urandom, $urandom, $urandom}; b0 = a0;
    b0[32 +: 32] = ~a0[32 +: 32];
    v0 = 1; step0();
    #2 rst_n = 0; model_reset();
    #1;
    total++;
    if ({rdy0, rv0, mm0, ef0, fc0, bc0, ec0, st0} !== '0) begin
      bad++; $display("FAIL async_reset got=%h want=0", {rdy0, rv0, mm0, ef0, fc0, bc0, ec0, st0});
    end
    @(posedge clk); #3 rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      step0();
      if (rv0 !== 1'b0) late++;
    end
    v0 = 0;
    total++;
    if (late != 0 || st0 !== 2'd0 || bc0 !== 16'd0) begin
      bad++; $display("FAIL post_reset late_rv=%0d st=%0d beat=%0d want 0/0/0", late, st0, bc0);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_halt();
    test_ch_en();
    test_selftest();
    test_random();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
